// File: rtl/escalonador_datapath_pkg.sv
// escalonador_datapath_pkg: shared state encoding and default sizing for the scheduler
package escalonador_datapath_pkg;
  localparam int N_REQ_DEF       = 4;
  localparam int DATA_W_DEF      = 8;
  localparam int TIMEOUT_DEF     = 15;
  localparam int CONTROL_LATENCY = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_START = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERR   = 3'd5
  } state_e;
endpackage

// File: rtl/escalonador_datapath_arbitro_rr.sv
// arbitro_rr: combinational round-robin pick of the first request after ptr
module arbitro_rr
  import escalonador_datapath_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [2:0]       ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [2:0]       idx_o,
  output logic             valid_o
);
  logic [2*N_REQ-1:0] dbl;
  logic [2:0]         off;

  // Rotate so bit 0 is requester ptr+1, then take the lowest set bit as the offset
  always_comb begin
    dbl = {req_i, req_i} >> ({1'b0, ptr_i} + 4'd1);
    off = '0;
    for (int j = N_REQ - 1; j >= 0; j--) off = dbl[j] ? 3'(j) : off;
    idx_o = 3'((32'(ptr_i) + 32'd1 + 32'(off)) % N_REQ);
  end

  assign valid_o = |req_i;
  assign gnt_o   = valid_o ? (N_REQ'(1) << idx_o) : '0;
endmodule

// File: rtl/escalonador_datapath.sv
// escalonador_datapath: round-robin sharing of one controller/datapath pair between requesters
module escalonador_datapath
  import escalonador_datapath_pkg::*;
#(
  parameter int N_REQ   = N_REQ_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] x_in,
  output logic [N_REQ-1:0]        ack,
  output logic [DATA_W-1:0]       result,
  output logic                    err,
  output logic                    busy,
  output logic [2:0]              grant_id,
  output logic                    dp_rst,
  output logic                    dp_inicio,
  output logic [DATA_W-1:0]       dp_x,
  input  logic                    dp_pronto,
  input  logic [DATA_W-1:0]       dp_result
);
  localparam int CW = $clog2(TIMEOUT + 1);

  state_e            state_q;
  logic [2:0]        ptr_q;
  logic [2:0]        grant_q;
  logic [DATA_W-1:0] dpx_q;
  logic [DATA_W-1:0] result_q;
  logic [CW-1:0]     cnt_q;
  logic [N_REQ-1:0]  gnt;
  logic [2:0]        idx;
  logic              any;
  logic [DATA_W-1:0] opnd;

  arbitro_rr #(.N_REQ(N_REQ)) u_arb (
    .req_i  (req),
    .ptr_i  (ptr_q),
    .gnt_o  (gnt),
    .idx_o  (idx),
    .valid_o(any)
  );

  // One-hot grant selects the winner's operand
  always_comb begin
    opnd = '0;
    for (int i = 0; i < N_REQ; i++) opnd |= gnt[i] ? x_in[i*DATA_W +: DATA_W] : '0;
  end

  // Sequencer: clear the controller, start it, wait for pronto or timeout, then report
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      ptr_q    <= 3'(N_REQ - 1);
      grant_q  <= '0;
      dpx_q    <= '0;
      result_q <= '0;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (any) begin
          grant_q <= idx;
          dpx_q   <= opnd;
          state_q <= ST_CLEAR;
        end
        ST_CLEAR: state_q <= ST_START;
        ST_START: begin
          cnt_q   <= '0;
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          cnt_q <= cnt_q + 1'b1;
          if (dp_pronto) begin
            result_q <= dp_result;
            state_q  <= ST_DONE;
          end else if (cnt_q == CW'(TIMEOUT - 1)) begin
            result_q <= '0;
            state_q  <= ST_ERR;
          end
        end
        ST_DONE, ST_ERR: begin
          ptr_q   <= grant_q;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ack       = (state_q == ST_DONE || state_q == ST_ERR) ? (N_REQ'(1) << grant_q) : '0;
  assign err       = state_q == ST_ERR;
  assign busy      = state_q != ST_IDLE;
  assign grant_id  = grant_q;
  assign result    = result_q;
  assign dp_x      = dpx_q;
  assign dp_inicio = state_q == ST_START;
  assign dp_rst    = ~rst | (state_q == ST_CLEAR);
endmodule

// File: tb/tb_escalonador_datapath.sv
// tb_escalonador_datapath: scoreboard bench with a latency-8 controller model
module tb_escalonador_datapath;
  import escalonador_datapath_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req = '0;
  logic [31:0] x_in = {8'h33, 8'h22, 8'h11, 8'h05};
  logic [3:0]  ack;
  logic [7:0]  result, dp_x, dp_result;
  logic        err, busy, dp_rst, dp_inicio, dp_pronto;
  logic [2:0]  grant_id;

  escalonador_datapath dut (
    .clk(clk), .rst(rst), .req(req), .x_in(x_in), .ack(ack), .result(result),
    .err(err), .busy(busy), .grant_id(grant_id), .dp_rst(dp_rst),
    .dp_inicio(dp_inicio), .dp_x(dp_x), .dp_pronto(dp_pronto), .dp_result(dp_result)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Controller model: pronto in the 8th cycle counting START, held until dp_rst
  int   mcnt = 0;
  logic hang = 1'b0;
  logic force_p = 1'b0;
  always @(posedge clk)
    if (dp_rst) mcnt <= 0;
    else if (dp_inicio) mcnt <= 2;
    else if (mcnt != 0 && mcnt < CONTROL_LATENCY) mcnt <= mcnt + 1;
  assign dp_pronto = (mcnt >= CONTROL_LATENCY && !hang) || force_p;
  assign dp_result = {dp_x[4:0], 3'b010};

  int nchk = 0;
  int nerr = 0;
  int k;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    nchk++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, a, e, cyc);
    end
  endtask

  typedef struct {
    logic [3:0] ack;
    logic [7:0] res;
    logic       err;
    int         id;
    int         cyc;
  } exp_t;
  exp_t q[$];
  exp_t ee;

  task automatic push(input logic [3:0] a, input logic [7:0] r, input logic e, input int id, input int c);
    q.push_back('{a, r, e, id, c});
  endtask

  // Monitor: every ack pulse is matched against the oldest expectation
  always @(negedge clk)
    if (ack !== 4'b0) begin
      if (q.size() == 0) chk("unexpected_ack", 32'(ack), 32'h0);
      else begin
        ee = q.pop_front();
        chk("ack", 32'(ack), 32'(ee.ack));
        chk("result", 32'(result), 32'(ee.res));
        chk("err", 32'(err), 32'(ee.err));
        chk("grant_id", 32'(grant_id), 32'(ee.id));
        chk("ack_cycle", 32'(cyc), 32'(ee.cyc));
      end
    end

  task automatic at(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rst_go(input logic [3:0] r);
    rst = 1'b0;
    at(cyc + 2);
    req = r;
    rst = 1'b1;
    k = cyc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    at(2);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_result", 32'(result), 0);
    chk("rst_dp_rst", 32'(dp_rst), 1);
    chk("rst_dp_x", 32'(dp_x), 0);
    chk("rst_inicio", 32'(dp_inicio), 0);

    // Single request
    rst_go(4'b0001);
    push(4'b0001, 8'h2A, 1'b0, 0, k + 10);
    at(k + 1);  chk("t1_busy", 32'(busy), 1); chk("t1_clear", 32'(dp_rst), 1);
    at(k + 2);  chk("t1_inicio", 32'(dp_inicio), 1); chk("t1_rst_low", 32'(dp_rst), 0);
    at(k + 3);  chk("t1_dp_x", 32'(dp_x), 32'h05);
    at(k + 10); chk("t1_busy_done", 32'(busy), 1); req = 4'b0;
    at(k + 11); chk("t1_busy_fall", 32'(busy), 0); chk("t1_ack_fall", 32'(ack), 0);
    chk("t1_result_held", 32'(result), 32'h2A);

    // All requesters held from reset
    rst_go(4'b1111);
    push(4'b0001, 8'h2A, 1'b0, 0, k + 10);
    push(4'b0010, 8'h8A, 1'b0, 1, k + 21);
    push(4'b0100, 8'h12, 1'b0, 2, k + 32);
    push(4'b1000, 8'h9A, 1'b0, 3, k + 43);
    push(4'b0001, 8'h2A, 1'b0, 0, k + 54);
    at(k + 13); chk("t2_dp_x1", 32'(dp_x), 32'h11);
    at(k + 35); chk("t2_dp_x3", 32'(dp_x), 32'h33);
    at(k + 54); req = 4'b0;
    at(k + 56); chk("t2_idle", 32'(busy), 0);

    // Fairness: late req[1] is served before req[2]
    rst_go(4'b0101);
    push(4'b0001, 8'h2A, 1'b0, 0, k + 10);
    push(4'b0010, 8'h8A, 1'b0, 1, k + 21);
    push(4'b0100, 8'h12, 1'b0, 2, k + 32);
    at(k + 3);  req = 4'b0111;
    at(k + 32); req = 4'b0;
    at(k + 34);

    // Hung controller, then a normal request
    hang = 1'b1;
    rst_go(4'b0001);
    push(4'b0001, 8'h00, 1'b1, 0, k + 18);
    at(k + 18); req = 4'b0; hang = 1'b0;
    at(k + 19); req = 4'b0010;
    push(4'b0010, 8'h8A, 1'b0, 1, k + 29);
    at(k + 20); chk("t4_clear", 32'(dp_rst), 1);
    at(k + 21); chk("t4_clear_end", 32'(dp_rst), 0); chk("t4_start", 32'(dp_inicio), 1);
    at(k + 29); req = 4'b0;
    at(k + 31);

    // Reset in WAIT aborts silently; requester 0 wins after release
    rst_go(4'b0001);
    at(k + 5); req = 4'b0011; rst = 1'b0;
    #1;
    chk("t5_busy", 32'(busy), 0);
    chk("t5_dp_rst", 32'(dp_rst), 1);
    chk("t5_grant", 32'(grant_id), 0);
    chk("t5_dp_x", 32'(dp_x), 0);
    rst_go(4'b0011);
    push(4'b0001, 8'h2A, 1'b0, 0, k + 10);
    push(4'b0010, 8'h8A, 1'b0, 1, k + 21);
    at(k + 10); req = 4'b0010;
    at(k + 21); req = 4'b0;
    at(k + 23);

    // Dropped req still acked; pronto in IDLE ignored
    rst_go(4'b0100);
    push(4'b0100, 8'h12, 1'b0, 2, k + 10);
    at(k + 5);  req = 4'b0;
    at(k + 12); force_p = 1'b1;
    at(k + 14); chk("t6_idle", 32'(busy), 0); force_p = 1'b0;
    at(k + 16);

    chk("queue_drained", 32'(q.size()), 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/escalonador_datapath.md
Name: escalonador_datapath

Overview:
Shares one polynomial/accumulator datapath and its control block between N_REQ requesters. Arbitration is round-robin. For each operation the block clears the control block, starts it with the winner's operand, and waits for pronto. It then returns the result and a one-cycle ack to the winner. A timeout guards against a hung control block. It sits between the requesting units and the blocoControle/datapath pair.

Parameters:
N_REQ, 4, number of requesters (2..8)
DATA_W, 8, operand and result width
TIMEOUT, 15, maximum WAIT cycles before abort (must exceed controller latency of 8)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
req  in  N_REQ  per-requester request, level, held until ack
x_in  in  N_REQ*DATA_W  packed operands; requester i uses bits [i*DATA_W +: DATA_W]
ack  out  N_REQ  one-hot, one-cycle completion pulse to the served requester
result  out  DATA_W  result of last operation, valid while ack is high, held afterwards
err  out  1  one-cycle pulse with ack when the operation timed out
busy  out  1  high in every state except IDLE
grant_id  out  3  index of current/last served requester
dp_rst  out  1  active-high reset to the controller; high while rst low or in CLEAR
dp_inicio  out  1  start to the controller; high in START only
dp_x  out  DATA_W  latched operand to the datapath, stable from CLEAR to DONE
dp_pronto  in  1  controller done flag (level; the controller holds it until reset)
dp_result  in  DATA_W  datapath result, valid while dp_pronto is high

Behaviour:
- Reset (rst=0, async): state=IDLE; ack=0, err=0, busy=0, result=0, grant_id=0, dp_x=0, dp_inicio=0. Round-robin pointer ptr=N_REQ-1, so requester 0 has first priority. dp_rst=1 for the whole reset. Reset mid-operation aborts silently with no ack.
- FSM states: IDLE, CLEAR, START, WAIT, DONE, ERR. Outputs decode from registered state; result/err/grant_id/dp_x are registers.
- IDLE: if any req bit is set, pick the first set bit searching ptr+1, ptr+2, … modulo N_REQ. Latch grant_id and dp_x from that requester's operand, then go to CLEAR. If no req, stay in IDLE.
- CLEAR: dp_rst=1 for exactly one cycle, then START. This is required because the controller latches pronto until it is reset.
- START: dp_inicio=1 for one cycle; clear the wait counter; then WAIT.
- WAIT: the counter increments each cycle.
  - dp_pronto=1 takes priority: result<=dp_result, go to DONE.
  - Otherwise, when the counter reaches TIMEOUT: result<=0, go to ERR.
- DONE: ack[grant_id]=1 for one cycle; ptr<=grant_id; go to IDLE.
- ERR: ack[grant_id]=1 and err=1 for one cycle; ptr<=grant_id; go to IDLE.
- Latency with the 9-state controller: ack is high in the 10th cycle after the edge that samples req in IDLE. Back-to-back operations take 11 cycles each, with 1 IDLE cycle between them.
- Request timing:
  - A req arriving while busy waits.
  - A req dropped while its operation runs does not abort it; ack is still pulsed.
  - A req still high in the cycle after ack is eligible again, but loses to any other pending requester.
- Operand changes on x_in after IDLE are ignored.
- dp_pronto outside WAIT is ignored.

Decomposition:
- Shared package holds:
  - State encoding constants (ST_IDLE=0 … ST_ERR=5, 3-bit).
  - Default N_REQ/DATA_W/TIMEOUT.
  - CONTROL_LATENCY=8, used by the bench.
- One sub-module, arbitro_rr:
  - Inputs: req vector and ptr.
  - Outputs: one-hot grant, grant index and any-valid flag.
  - Purely combinational, instantiated once.

Test Plan:
- Single request: req=0001, x_in[0]=8'h05, controller model returns 8'h2A → ack=0001 exactly 10 cycles after sampling, result=8'h2A, err=0, busy falls the same cycle ack falls.
- All requesters held high from reset: service order is 0,1,2,3,0; each ack is 11 cycles apart; dp_x matches each requester's operand.
- Fairness: req=0101 held, req[1] raised during service of 0 → order 0,1,2, not 0,2.
- Hung controller (dp_pronto never set): ack=0001 with err=1 at WAIT count 15; result=0; next request proceeds normally, with dp_rst pulsed in CLEAR.
- rst low in WAIT: all outputs 0 and dp_rst=1 immediately (asynchronous); no ack. After release, pending req=0010 is served, with requester 0 first if both are pending.
- req[2] dropped in WAIT: op completes, ack=0100 still pulsed; dp_pronto asserted while in IDLE is ignored.
